// File: rtl/plic_irq_gateway.sv
// Interrupt gateway array feeding the PLIC core. Each source synchronizes its raw line,
// applies level or rising-edge semantics and holds one request until claim/complete.
module plic_irq_gateway #(
  parameter int irqmax    = 73,
  parameter int edgecnt_w = 3
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic [irqmax-1:0] i_irq,
  input  logic [irqmax-1:0] i_edge_mode,
  input  logic              i_claim_valid,
  input  logic [9:0]        i_claim_id,
  input  logic              i_complete_valid,
  input  logic [9:0]        i_complete_id,
  output logic [irqmax-1:0] o_pending,
  output logic [irqmax-1:0] o_inflight
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_INFL = 2'd2
  } state_t;

  localparam logic [edgecnt_w-1:0] CNT_MAX = '1;

  // Source 0 is reserved: its input bits are consumed here only to keep them accounted for.
  logic w_unused_src0;
  assign w_unused_src0 = i_irq[0] ^ i_edge_mode[0];

  assign o_pending[0]  = 1'b0;
  assign o_inflight[0] = 1'b0;

  // Handshake: claim/complete are single-cycle strobes with no back-pressure; a strobe is
  // consumed on the clock edge where it is high and only by the source whose state matches.
  for (genvar gi = 1; gi < irqmax; gi++) begin : g_src
    logic                 r_s1, r_s2, r_s3, r_mode;
    logic [edgecnt_w-1:0] r_cnt, w_cnt_nxt;
    state_t               r_state, w_state_nxt;
    logic                 w_rise, w_claim, w_complete, w_mode, w_dec;

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_s3    <= 1'b0;
        r_mode  <= 1'b0;
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_s1    <= i_irq[gi];
        r_s2    <= r_s1;
        r_s3    <= r_s2;
        r_mode  <= w_mode;
        r_cnt   <= w_cnt_nxt;
        r_state <= w_state_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dec       = 1'b0;
      // Mode only tracks the input while nothing is queued, so a switch never splits a request.
      w_mode      = (r_state == ST_IDLE && r_cnt == '0) ? i_edge_mode[gi] : r_mode;
      w_rise      = r_s2 & ~r_s3;
      w_claim     = i_claim_valid && (i_claim_id == 10'(gi));
      w_complete  = i_complete_valid && (i_complete_id == 10'(gi));

      case (r_state)
        ST_IDLE: begin
          if (w_mode) begin
            if (r_cnt != '0) begin
              w_state_nxt = ST_PEND;
              w_dec       = 1'b1;
            end
          end else if (r_s2) begin
            w_state_nxt = ST_PEND;
          end
        end
        ST_PEND: if (w_claim)    w_state_nxt = ST_INFL;
        ST_INFL: if (w_complete) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase

      // A rise coinciding with a hand-off cancels out; a rise at CNT_MAX is dropped.
      if (w_mode) begin
        if (w_rise && !w_dec && r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
        else if (!w_rise && w_dec)                w_cnt_nxt = r_cnt - 1'b1;
      end
    end

    assign o_pending[gi]  = (r_state == ST_PEND);
    assign o_inflight[gi] = (r_state == ST_INFL);
  end

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Directed bench for plic_irq_gateway: level/edge sources, claim/complete handshakes,
// counter saturation, concurrent strobes and asynchronous reset.
module tb_plic_irq_gateway;
  localparam int N = 73;

  logic         clk;
  logic         nrst;
  logic [N-1:0] irq;
  logic [N-1:0] edge_mode;
  logic         claim_valid;
  logic [9:0]   claim_id;
  logic         complete_valid;
  logic [9:0]   complete_id;
  logic [N-1:0] pending;
  logic [N-1:0] inflight;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] e;

  plic_irq_gateway #(.irqmax(N), .edgecnt_w(3)) dut (
    .i_clk            (clk),
    .i_nrst           (nrst),
    .i_irq            (irq),
    .i_edge_mode      (edge_mode),
    .i_claim_valid    (claim_valid),
    .i_claim_id       (claim_id),
    .i_complete_valid (complete_valid),
    .i_complete_id    (complete_id),
    .o_pending        (pending),
    .o_inflight       (inflight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic claim(input int id);
    claim_valid = 1'b1;
    claim_id    = 10'(id);
    step();
    claim_valid = 1'b0;
    claim_id    = '0;
  endtask

  task automatic complete(input int id);
    complete_valid = 1'b1;
    complete_id    = 10'(id);
    step();
    complete_valid = 1'b0;
    complete_id    = '0;
  endtask

  task automatic pulse(input int idx);
    irq[idx] = 1'b1;
    repeat (3) step();
    irq[idx] = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    nrst           = 1'b0;
    irq            = '0;
    edge_mode      = '0;
    claim_valid    = 1'b0;
    claim_id       = '0;
    complete_valid = 1'b0;
    complete_id    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkv("rst_pending", pending, '0);
    checkv("rst_inflight", inflight, '0);
    nrst = 1'b1;
    step();
    irq[0] = 1'b1;

    // Level source 5: two-flop sync plus FSM gives pending on the third edge.
    irq[5] = 1'b1;
    step();
    step();
    check1("lvl_latency_early", pending[5], 1'b0);
    step();
    check1("lvl_latency", pending[5], 1'b1);

    complete(5);
    check1("complete_on_pend_keeps", pending[5], 1'b1);
    check1("complete_on_pend_noinfl", inflight[5], 1'b0);

    claim(0);
    claim(80);
    claim(73);
    e = '0;
    e[5] = 1'b1;
    checkv("bad_ids_pending", pending, e);
    checkv("bad_ids_inflight", inflight, '0);

    claim(9);
    checkv("claim_idle_src9_pend", pending, e);
    checkv("claim_idle_src9_infl", inflight, '0);

    claim(5);
    check1("claim_clears_pend", pending[5], 1'b0);
    check1("claim_sets_infl", inflight[5], 1'b1);

    complete(5);
    check1("complete_idle_pend", pending[5], 1'b0);
    check1("complete_idle_infl", inflight[5], 1'b0);
    step();
    check1("lvl_repend", pending[5], 1'b1);

    irq[5] = 1'b0;
    claim(5);
    complete(5);
    repeat (3) step();
    checkv("lvl_idle_pending", pending, '0);
    checkv("lvl_idle_inflight", inflight, '0);

    // Edge source 7: three pulses produce exactly three rounds.
    edge_mode[7] = 1'b1;
    pulse(7);
    pulse(7);
    pulse(7);
    repeat (2) step();
    for (int r = 0; r < 3; r++) begin
      check1("edge_round_pend", pending[7], 1'b1);
      claim(7);
      check1("edge_round_infl", inflight[7], 1'b1);
      complete(7);
      step();
    end
    check1("edge_after3_idle", pending[7], 1'b0);
    repeat (3) step();
    check1("edge_after3_stay", pending[7], 1'b0);

    // Saturation: ten pulses while in flight leave seven queued rounds.
    pulse(7);
    repeat (2) step();
    check1("sat_setup_pend", pending[7], 1'b1);
    claim(7);
    check1("sat_setup_infl", inflight[7], 1'b1);
    for (int p = 0; p < 10; p++) pulse(7);
    repeat (2) step();
    complete(7);
    step();
    for (int r = 0; r < 7; r++) begin
      check1("sat_round_pend", pending[7], 1'b1);
      claim(7);
      complete(7);
      step();
    end
    check1("sat_done_idle", pending[7], 1'b0);
    repeat (3) step();
    check1("sat_done_stay", pending[7], 1'b0);

    // Rise and decrement on the same edge: count stays at one, giving two rounds.
    pulse(7);
    repeat (2) step();
    claim(7);
    check1("rd_setup_infl", inflight[7], 1'b1);
    pulse(7);
    repeat (2) step();
    irq[7] = 1'b1;
    step();
    complete(7);
    step();
    irq[7] = 1'b0;
    check1("rd_first_pend", pending[7], 1'b1);
    claim(7);
    complete(7);
    step();
    check1("rd_second_pend", pending[7], 1'b1);
    claim(7);
    complete(7);
    step();
    check1("rd_then_idle", pending[7], 1'b0);
    repeat (3) step();
    check1("rd_stay_idle", pending[7], 1'b0);

    // Concurrent strobes on sources 3 and 4.
    irq[3] = 1'b1;
    irq[4] = 1'b1;
    repeat (3) step();
    e = '0;
    e[3] = 1'b1;
    e[4] = 1'b1;
    checkv("conc_both_pend", pending, e);
    claim(4);
    check1("conc_src4_infl", inflight[4], 1'b1);
    irq[3]         = 1'b0;
    irq[4]         = 1'b0;
    claim_valid    = 1'b1;
    claim_id       = 10'd3;
    complete_valid = 1'b1;
    complete_id    = 10'd4;
    step();
    claim_valid    = 1'b0;
    complete_valid = 1'b0;
    check1("conc_src3_infl", inflight[3], 1'b1);
    check1("conc_src3_notpend", pending[3], 1'b0);
    check1("conc_src4_done", inflight[4], 1'b0);
    check1("conc_src4_idle", pending[4], 1'b0);
    step();
    check1("conc_src4_repend", pending[4], 1'b1);
    claim_valid    = 1'b1;
    claim_id       = 10'd4;
    complete_valid = 1'b1;
    complete_id    = 10'd3;
    step();
    claim_valid    = 1'b0;
    complete_valid = 1'b0;
    check1("conc2_src4_infl", inflight[4], 1'b1);
    check1("conc2_src3_done", inflight[3], 1'b0);
    complete(4);
    repeat (3) step();
    checkv("conc_end_pending", pending, '0);
    checkv("conc_end_inflight", inflight, '0);

    // Reset mid-flight: source 2 in flight, source 6 pending with two queued edges.
    irq[2] = 1'b1;
    repeat (3) step();
    claim(2);
    irq[2] = 1'b0;
    check1("mid_src2_infl", inflight[2], 1'b1);
    edge_mode[6] = 1'b1;
    pulse(6);
    pulse(6);
    pulse(6);
    repeat (2) step();
    check1("mid_src6_pend", pending[6], 1'b1);
    #2 nrst = 1'b0;
    #1;
    checkv("async_rst_pending", pending, '0);
    checkv("async_rst_inflight", inflight, '0);
    #2 nrst = 1'b1;
    repeat (5) step();
    checkv("post_rst_pending", pending, '0);
    checkv("post_rst_inflight", inflight, '0);

    // Line held high across reset release is seen as a rise.
    irq[6] = 1'b1;
    step();
    step();
    #2 nrst = 1'b0;
    #2 nrst = 1'b1;
    repeat (3) step();
    check1("held_high_early", pending[6], 1'b0);
    step();
    check1("held_high_rise", pending[6], 1'b1);
    check1("src0_never_pend", pending[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
